// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the store buffer, bundled for one port.
// slave: the buffer itself; master: the core/memory environment that drives it.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_memwrite;
    logic [AW-1:0] cpu_memaddr;
    logic [DW-1:0] cpu_memwritedata;
    logic [DW-1:0] cpu_memreaddata;
    logic          cpu_stall;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          mem_wvalid;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wready;
    logic          flush_req;
    logic          flush_done;

    modport slave (
        input  cpu_memwrite, cpu_memaddr, cpu_memwritedata, mem_rdata, mem_wready, flush_req,
        output cpu_memreaddata, cpu_stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, flush_done
    );

    modport master (
        output cpu_memwrite, cpu_memaddr, cpu_memwritedata, mem_rdata, mem_wready, flush_req,
        input  cpu_memreaddata, cpu_stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, flush_done
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer between core MEM stage and data memory; STOREBUF_COALESCE_EN merges same-word stores into the youngest entry.
// Latency: stores accepted with zero latency, loads forwarded combinationally, an entry is offered to memory the cycle after enqueue.
// Backpressure: cpu_stall on a store when full (unless it coalesces) or while flushing; mem_wready only paces draining.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    entry_t        entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] youngest;
    logic [CW-1:0] count;
    state_t        state;
    state_t        state_nxt;

    logic          empty;
    logic          full;
    logic          wvalid;
    logic          pop;
    logic          coalesce_hit;
    logic          stall;
    logic          push;
    logic          push_alloc;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] scan_idx;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign youngest = tail - PW'(1);
    assign wvalid   = !empty;
    assign pop      = wvalid && bus.mem_wready;

`ifdef STOREBUF_COALESCE_EN
    // A lone entry that is leaving this cycle cannot absorb the store.
    assign coalesce_hit = !empty
                       && (entries[youngest].addr[AW-1:2] == bus.cpu_memaddr[AW-1:2])
                       && !((youngest == head) && pop);
`else
    assign coalesce_hit = 1'b0;
`endif

    assign stall      = bus.cpu_memwrite && ((state == FLUSH) || (full && !coalesce_hit));
    assign push       = bus.cpu_memwrite && !stall;
    assign push_alloc = push && !coalesce_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)
                head <= head + PW'(1);
            if (push_alloc)
                tail <= tail + PW'(1);
            case ({push_alloc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset: validity comes from head/count.
    always_ff @(posedge clk) begin
        if (push_alloc) begin
            entries[tail].addr <= bus.cpu_memaddr;
            entries[tail].data <= bus.cpu_memwritedata;
        end else if (push) begin
            entries[youngest].data <= bus.cpu_memwritedata;
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_data = bus.mem_rdata;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if ((CW'(k) < count) && (entries[scan_idx].addr[AW-1:2] == bus.cpu_memaddr[AW-1:2]))
                fwd_data = entries[scan_idx].data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.flush_req) state_nxt = FLUSH;
            FLUSH:   if (empty)         state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cpu_stall       = stall;
    assign bus.cpu_memreaddata = fwd_data;
    assign bus.mem_raddr       = bus.cpu_memaddr;
    assign bus.mem_wvalid      = wvalid;
    assign bus.mem_waddr       = entries[head].addr;
    assign bus.mem_wdata       = entries[head].data;
    assign bus.flush_done      = (state == DONE);
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
`ifdef STOREBUF_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.AW(AW), .DW(DW)) sif();
    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(sif));

    int tests = 0;
    int fails = 0;

    ent_t mq[$];
    ent_t exp_wr[$];
    ent_t act_wr[$];
    int   mphase = 0;   // 0 idle, 1 flushing, 2 done pulse

    logic          cur_wr, cur_freq;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] cur_d;
    logic          m_pop, m_coal;
    logic          e_stall, e_wvalid, e_done;
    logic [DW-1:0] e_rdata;
    ent_t          e_head;

    always @(posedge clk)
        if (reset && sif.mem_wvalid && sif.mem_wready)
            act_wr.push_back('{sif.mem_waddr, sif.mem_wdata});

    task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic wrdy, input logic freq, input logic [DW-1:0] rw);
        sif.cpu_memwrite     = wr;
        sif.cpu_memaddr      = a;
        sif.cpu_memwritedata = d;
        sif.mem_wready       = wrdy;
        sif.flush_req        = freq;
        sif.mem_rdata        = rw;
        cur_wr = wr; cur_a = a; cur_d = d; cur_freq = freq;
        #1;
        e_wvalid = (mq.size() != 0);
        e_head   = e_wvalid ? mq[0] : '0;
        m_pop    = e_wvalid && wrdy;
        m_coal   = COAL && (mq.size() != 0) && (mq[mq.size()-1].addr[AW-1:2] == a[AW-1:2])
                   && !(mq.size() == 1 && m_pop);
        e_stall  = wr && (mphase == 1 || (mq.size() == DEPTH && !m_coal));
        e_done   = (mphase == 2);
        e_rdata  = rw;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].addr[AW-1:2] == a[AW-1:2]) begin
                e_rdata = mq[i].data;
                break;
            end
    endtask

    task automatic step();
        logic psh;
        int   nph;
        psh = cur_wr && !e_stall;
        nph = mphase;
        if (mphase == 0 && cur_freq)          nph = 1;
        else if (mphase == 1 && mq.size() == 0) nph = 2;
        else if (mphase == 2)                 nph = 0;
        if (psh && m_coal) mq[mq.size()-1].data = cur_d;
        if (m_pop) begin
            exp_wr.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (psh && !m_coal) mq.push_back('{cur_a, cur_d});
        mphase = nph;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        drive(1'b0, '0, '0, 1'b1, 1'b0, $urandom);
        while ((sif.mem_wvalid || mphase != 0) && n < 40) begin
            step();
            drive(1'b0, '0, '0, 1'b1, 1'b0, $urandom);
            n++;
        end
        tests++;
        if (n >= 40) begin
            fails++;
            $display("FAIL drain_timeout: wvalid=%0b after %0d cycles, required 0", sif.mem_wvalid, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sif.cpu_memwrite = 1'b1; sif.cpu_memaddr = 32'h40; sif.cpu_memwritedata = 32'h1;
        sif.mem_wready = 1'b1; sif.flush_req = 1'b0; sif.mem_rdata = 32'h0;
        #3;
        tests++;
        if (sif.mem_wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid: got %b required 0", sif.mem_wvalid); end
        tests++;
        if (sif.cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b required 0", sif.cpu_stall); end
        tests++;
        if (sif.flush_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", sif.flush_done); end
        sif.cpu_memwrite = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_stall();
        logic [AW-1:0] want;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, AW'(i * 4), DW'(32'h100 + i), 1'b0, 1'b0, $urandom);
            tests++;
            if (sif.cpu_stall !== (i == 4) || sif.cpu_stall !== e_stall) begin
                fails++; $display("FAIL fill_stall[%0d]: got %b required %b", i, sif.cpu_stall, (i == 4));
            end
            step();
        end
        drive(1'b1, 32'h10, 32'h104, 1'b1, 1'b0, $urandom);
        tests++;
        if (sif.cpu_stall !== 1'b1) begin fails++; $display("FAIL full_pop_stall: got %b required 1", sif.cpu_stall); end
        step();
        drive(1'b1, 32'h10, 32'h104, 1'b1, 1'b0, $urandom);
        tests++;
        if (sif.cpu_stall !== 1'b0) begin fails++; $display("FAIL after_pop_stall: got %b required 0", sif.cpu_stall); end
        step();
        drain();
        tests++;
        if (act_wr.size() != 5) begin
            fails++; $display("FAIL fill_write_count: got %0d required 5", act_wr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                want = AW'(i * 4);
                tests++;
                if (act_wr[i].addr !== want || act_wr[i].data !== DW'(32'h100 + i)) begin
                    fails++; $display("FAIL fill_write[%0d]: got %h/%h required %h/%h", i,
                                      act_wr[i].addr, act_wr[i].data, want, 32'h100 + i);
                end
            end
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_forward();
        drive(1'b1, 32'h20, 32'hAAAA, 1'b0, 1'b0, $urandom); step();
        drive(1'b1, 32'h20, 32'hBBBB, 1'b0, 1'b0, $urandom); step();
        drive(1'b0, 32'h22, 32'h0, 1'b0, 1'b0, 32'h5555);
        tests++;
        if (sif.cpu_memreaddata !== 32'hBBBB || sif.cpu_memreaddata !== e_rdata) begin
            fails++; $display("FAIL fwd_youngest: got %h required %h", sif.cpu_memreaddata, 32'hBBBB);
        end
        step();
        drive(1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h1234);
        tests++;
        if (sif.cpu_memreaddata !== 32'h1234) begin
            fails++; $display("FAIL fwd_miss: got %h required 1234", sif.cpu_memreaddata);
        end
        tests++;
        if (sif.mem_raddr !== 32'h40) begin fails++; $display("FAIL raddr: got %h required 40", sif.mem_raddr); end
        step();
        drain();
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_push_pop();
        drive(1'b1, 32'h100, 32'hD0, 1'b0, 1'b0, $urandom); step();
        drive(1'b1, 32'h104, 32'hD1, 1'b0, 1'b0, $urandom); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, $urandom);
            tests++;
            if (sif.mem_wvalid !== 1'b1 || sif.mem_waddr !== 32'h100 || sif.mem_wdata !== 32'hD0) begin
                fails++; $display("FAIL head_hold[%0d]: got %b %h/%h required 1 100/d0", i,
                                  sif.mem_wvalid, sif.mem_waddr, sif.mem_wdata);
            end
            step();
        end
        drive(1'b1, 32'h108, 32'hD2, 1'b1, 1'b0, $urandom);
        tests++;
        if (sif.cpu_stall !== 1'b0) begin fails++; $display("FAIL pushpop_stall: got %b required 0", sif.cpu_stall); end
        step();
        drive(1'b1, 32'h10C, 32'hD3, 1'b0, 1'b0, $urandom); step();
        drive(1'b1, 32'h110, 32'hD4, 1'b0, 1'b0, $urandom);
        tests++;
        if (sif.cpu_stall !== 1'b0) begin fails++; $display("FAIL count2_room: got %b required 0", sif.cpu_stall); end
        step();
        drive(1'b1, 32'h114, 32'hD5, 1'b0, 1'b0, $urandom);
        tests++;
        if (sif.cpu_stall !== 1'b1) begin fails++; $display("FAIL count2_full: got %b required 1", sif.cpu_stall); end
        step();
        drain();
        tests++;
        if (act_wr.size() != 5 || act_wr[0].data !== 32'hD0 || act_wr[4].data !== 32'hD4) begin
            fails++; $display("FAIL pushpop_writes: got %0d writes, required 5 ending d4", act_wr.size());
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_flush();
        logic wr, wrdy, freq;
        drive(1'b1, 32'h200, 32'hF0, 1'b0, 1'b0, $urandom); step();
        drive(1'b1, 32'h204, 32'hF1, 1'b0, 1'b0, $urandom); step();
        for (int c = 0; c < 6; c++) begin
            wr   = (c >= 1 && c <= 3);
            wrdy = (c == 0 || c == 2);
            freq = (c <= 1);
            drive(wr, 32'h300, 32'hEE, wrdy, freq, $urandom);
            tests++;
            if (sif.cpu_stall !== wr || sif.cpu_stall !== e_stall) begin
                fails++; $display("FAIL flush_stall[%0d]: got %b required %b", c, sif.cpu_stall, wr);
            end
            tests++;
            if (sif.flush_done !== (c == 4) || sif.flush_done !== e_done) begin
                fails++; $display("FAIL flush_done[%0d]: got %b required %b", c, sif.flush_done, (c == 4));
            end
            step();
        end
        for (int c = 0; c < 4; c++) begin
            drive(c == 1, 32'h304, 32'hEF, 1'b1, c == 0, $urandom);
            tests++;
            if (sif.flush_done !== (c == 2)) begin
                fails++; $display("FAIL empty_flush_done[%0d]: got %b required %b", c, sif.flush_done, (c == 2));
            end
            if (c == 1) begin
                tests++;
                if (sif.cpu_stall !== 1'b1) begin fails++; $display("FAIL empty_flush_stall: got %b required 1", sif.cpu_stall); end
            end
            step();
        end
        drain();
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(32'h400 + i * 4), DW'(i), 1'b0, 1'b0, $urandom);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, $urandom);
        #2 reset = 1'b0;
        #1;
        tests++;
        if (sif.mem_wvalid !== 1'b0) begin fails++; $display("FAIL midreset_wvalid: got %b required 0", sif.mem_wvalid); end
        mq.delete(); mphase = 0; exp_wr.delete(); act_wr.delete();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, $urandom);
            step();
        end
        tests++;
        if (act_wr.size() != 0 || sif.mem_wvalid !== 1'b0) begin
            fails++; $display("FAIL midreset_writes: got %0d writes, required 0", act_wr.size());
        end
    endtask

    task automatic test_full_same_word();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(32'h500 + i * 4), DW'(32'hC0 + i), 1'b0, 1'b0, $urandom);
            step();
        end
        drive(1'b1, 32'h50D, 32'hCAFE, 1'b0, 1'b0, $urandom);
        tests++;
        if (sif.cpu_stall !== !COAL) begin fails++; $display("FAIL full_coalesce_stall: got %b required %b", sif.cpu_stall, !COAL); end
        step();
        drive(1'b1, 32'h600, 32'h1, 1'b0, 1'b0, $urandom);
        tests++;
        if (sif.cpu_stall !== 1'b1) begin fails++; $display("FAIL still_full: got %b required 1", sif.cpu_stall); end
        step();
        drain();
        tests++;
        if (act_wr.size() != 4 || act_wr[3].data !== (COAL ? 32'hCAFE : 32'hC3)) begin
            fails++; $display("FAIL coalesce_drain: got %0d writes, required 4 ending %h", act_wr.size(),
                              COAL ? 32'hCAFE : 32'hC3);
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int n = 0; n < 1500; n++) begin
            a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            drive(1'($urandom), a, $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0), $urandom);
            tests++;
            if (sif.cpu_stall !== e_stall || sif.cpu_memreaddata !== e_rdata || sif.mem_raddr !== a
                || sif.mem_wvalid !== e_wvalid || sif.flush_done !== e_done
                || (e_wvalid && ({sif.mem_waddr, sif.mem_wdata} !== e_head))) begin
                fails++;
                $display("FAIL rand[%0d]: got stall=%b rd=%h wv=%b w=%h/%h done=%b required stall=%b rd=%h wv=%b w=%h/%h done=%b",
                         n, sif.cpu_stall, sif.cpu_memreaddata, sif.mem_wvalid, sif.mem_waddr, sif.mem_wdata,
                         sif.flush_done, e_stall, e_rdata, e_wvalid, e_head.addr, e_head.data, e_done);
            end
            step();
        end
        drain();
        tests++;
        if (act_wr.size() != exp_wr.size()) begin
            fails++; $display("FAIL rand_write_count: got %0d required %0d", act_wr.size(), exp_wr.size());
        end else begin
            for (int i = 0; i < act_wr.size(); i++) begin
                tests++;
                if (act_wr[i] !== exp_wr[i]) begin
                    fails++; $display("FAIL rand_write[%0d]: got %h/%h required %h/%h", i,
                                      act_wr[i].addr, act_wr[i].data, exp_wr[i].addr, exp_wr[i].data);
                end
            end
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_forward();
        test_push_pop();
        test_flush();
        test_reset_mid_drain();
        test_full_same_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
